// File: rtl/gate_chk_pkg.sv
// -----------------------------------------------------------------------------
// gate_chk_pkg
//   Shared definitions for the two-input gate BIST checker:
//     - FSM state encoding
//     - bit positions of each gate function inside the 8-bit gate_out bus
//     - the fixed expected-response table, indexed by the {a,b} vector
//     - a lookup helper used by the expected-response sub-module
// -----------------------------------------------------------------------------
package gate_chk_pkg;

    // Number of input vectors exercised per run ({a,b} = 00, 01, 10, 11).
    localparam int NUM_VEC = 4;

    // Width of the gate response bus.
    localparam int GATE_W = 8;

    // Checker sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions inside gate_out.
    localparam int AND_B  = 0;  // a & b
    localparam int OR_B   = 1;  // a | b
    localparam int NOT_B  = 2;  // ~a
    localparam int NOTB_B = 3;  // ~b
    localparam int NAND_B = 4;  // ~(a & b)
    localparam int NOR_B  = 5;  // ~(a | b)
    localparam int XOR_B  = 6;  // a ^ b
    localparam int XNOR_B = 7;  // ~(a ^ b)

    // Expected gate_out for each vector index {a,b}.
    //   00 -> BC, 01 -> 56, 10 -> 5A, 11 -> 83
    localparam logic [NUM_VEC-1:0][GATE_W-1:0] EXP_TABLE = {
        8'h83,  // {a,b} = 11
        8'h5A,  // {a,b} = 10
        8'h56,  // {a,b} = 01
        8'hBC   // {a,b} = 00
    };

    // Expected response for one vector index.
    function automatic logic [GATE_W-1:0] exp_of(input logic [1:0] vec);
        return EXP_TABLE[vec];
    endfunction

endpackage

// File: rtl/gate_expect.sv
// -----------------------------------------------------------------------------
// gate_expect
//   Purely combinational lookup of the expected 8-bit gate response for a
//   2-bit vector index {a,b}.
//
// Ports
//   vec       in   2  vector index, {a,b}
//   expected  out  8  expected gate_out for that vector (bit 0 = AND)
// -----------------------------------------------------------------------------
module gate_expect
    import gate_chk_pkg::*;
(
    input  logic [1:0]        vec,
    output logic [GATE_W-1:0] expected
);

    assign expected = exp_of(vec);

endmodule

// File: rtl/gate_bist_checker.sv
// -----------------------------------------------------------------------------
// gate_bist_checker
//   Built-in self-check for the two-input gate block. Drives the four {a,b}
//   vectors in order, lets each settle for SETTLE_CYC clocks, samples the
//   eight gate outputs and compares them with the fixed truth table.
//   Results (per-vector fail bits, first mismatch mask, pass/done) are sticky
//   until the next run or reset.
//
// Parameters
//   SETTLE_CYC  clocks between driving a vector and sampling it (1..15)
//
// Ports
//   clk         in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   start       in   1  begin a run (honoured in IDLE and DONE only)
//   a, b        out  1  registered gate inputs
//   gate_out    in   8  gate responses {xnor,xor,nor,nand,~b,~a,or,and}
//   busy        out  1  run in progress
//   done        out  1  run complete, results valid (sticky)
//   pass        out  1  done and no vector failed (sticky)
//   fail_vec    out  4  bit k set if vector k = {a,b} mismatched
//   first_diff  out  8  expected ^ sampled for the first failing vector
// -----------------------------------------------------------------------------
module gate_bist_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               a,
    output logic               b,
    input  logic [GATE_W-1:0]  gate_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] fail_vec,
    output logic [GATE_W-1:0]  first_diff
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    // The counter is cleared on the edge that drives a vector, so the sample
    // edge is the one where the counter moves from SETTLE_CYC-1 to SETTLE_CYC.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [1:0]       VEC_LAST = 2'(NUM_VEC - 1);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("gate_bist_checker: SETTLE_CYC=%0d outside legal range 1..15",
               SETTLE_CYC);
    end

    state_t            state;
    logic [1:0]        vec;
    logic [CNT_W-1:0]  cnt;

    logic [GATE_W-1:0] expected;
    logic [GATE_W-1:0] diff;
    logic              mismatch;
    logic              sample;
    logic              last_vec;

    gate_expect u_expect (
        .vec      (vec),
        .expected (expected)
    );

    assign diff     = expected ^ gate_out;
    assign mismatch = |diff;
    assign sample   = (cnt == CNT_LAST);
    assign last_vec = (vec == VEC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            cnt        <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_vec   <= '0;
            first_diff <= '0;
        end else begin
            case (state)
                // A new run from DONE behaves exactly like one from IDLE and
                // throws the previous results away on the start edge.
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        vec        <= '0;
                        cnt        <= '0;
                        a          <= 1'b0;
                        b          <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_vec   <= '0;
                        first_diff <= '0;
                    end
                end

                // start is deliberately not looked at here: a run in
                // progress can be neither restarted nor stretched.
                RUN: begin
                    if (sample) begin
                        // NOTE: non-blocking assignments mean fail_vec below
                        // is the value from before this edge, which is exactly
                        // what "first failing vector" needs.
                        if (mismatch) begin
                            fail_vec[vec] <= 1'b1;
                            if (fail_vec == '0) begin
                                first_diff <= diff;
                            end
                        end

                        cnt <= '0;
                        if (!last_vec) begin
                            vec    <= vec + 2'd1;
                            {a, b} <= vec + 2'd1;
                        end else begin
                            state  <= DONE;
                            {a, b} <= 2'b00;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            pass   <= (fail_vec == '0) && !mismatch;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_bist_checker
//   Three checker instances (SETTLE_CYC = 2, 1, 5) each looped back through a
//   behavioural gate model. Instance 0 can have a fault injected into its
//   model. Each launched run pushes its hand-computed expected result into a
//   scoreboard queue; a per-instance monitor pops and compares when done rises.
// -----------------------------------------------------------------------------
module tb_gate_bist_checker;

    localparam int N_DUT = 3;

    typedef struct {
        int         dut;
        int         done_cyc;
        logic [3:0] fail_vec;
        logic [7:0] first_diff;
        logic       pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_s      [N_DUT];
    logic       a_s          [N_DUT];
    logic       b_s          [N_DUT];
    logic [7:0] gate_s       [N_DUT];
    logic       busy_s       [N_DUT];
    logic       done_s       [N_DUT];
    logic       pass_s       [N_DUT];
    logic [3:0] fail_vec_s   [N_DUT];
    logic [7:0] first_diff_s [N_DUT];

    int   fault_mode = 0;   // 0 none, 1 xor stuck-at-0, 2 and inverted on 11
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int settle_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 5);
    endfunction

    // Behavioural gate block, written from the gate equations.
    function automatic logic [7:0] gate_model(input logic ia, input logic ib,
                                              input int fault);
        logic [7:0] y;
        y = {~(ia ^ ib), ia ^ ib, ~(ia | ib), ~(ia & ib), ~ib, ~ia, ia | ib, ia & ib};
        if (fault == 1) y[6] = 1'b0;
        if (fault == 2 && ia && ib) y[0] = ~y[0];
        return y;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

        gate_bist_checker #(.SETTLE_CYC(S)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start_s[g]),
            .a          (a_s[g]),
            .b          (b_s[g]),
            .gate_out   (gate_s[g]),
            .busy       (busy_s[g]),
            .done       (done_s[g]),
            .pass       (pass_s[g]),
            .fail_vec   (fail_vec_s[g]),
            .first_diff (first_diff_s[g])
        );

        assign gate_s[g] = gate_model(a_s[g], b_s[g], (g == 0) ? fault_mode : 0);

        // Monitor: compare against the scoreboard whenever done rises.
        logic done_q = 1'b0;
        always @(negedge clk) begin
            exp_t e;
            if (done_s[g] && !done_q) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done dut%0d at cycle %0d", g, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_dut",        g,               e.dut);
                    check("sb_done_cyc",   cyc,             e.done_cyc);
                    check("sb_fail_vec",   fail_vec_s[g],   e.fail_vec);
                    check("sb_first_diff", first_diff_s[g], e.first_diff);
                    check("sb_pass",       pass_s[g],       e.pass);
                    check("sb_busy",       busy_s[g],       1'b0);
                    check("sb_ab",         {a_s[g], b_s[g]}, 2'b00);
                end
            end
            done_q = done_s[g];
        end
    end

    // Start a run on instance d. start is held for 'hold' sampling edges.
    // When push is set the expected result goes to the scoreboard; done is
    // due 4*SETTLE_CYC edges after the start edge.
    task automatic launch(input int d, input logic [3:0] fv, input logic [7:0] fd,
                          input logic ps, input int hold, input bit push);
        exp_t e;
        @(negedge clk);
        if (push) begin
            e.dut        = d;
            e.done_cyc   = cyc + 1 + 4 * settle_of(d);
            e.fail_vec   = fv;
            e.first_diff = fd;
            e.pass       = ps;
            sb_q.push_back(e);
        end
        start_s[d] = 1'b1;
        repeat (hold) @(negedge clk);
        start_s[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while (!done_s[d] && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!done_s[d]) begin
            checks++;
            errors++;
            $display("FAIL done_timeout dut%0d: done=%0b required 1", d, done_s[d]);
        end
        @(negedge clk);
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_busy"},       busy_s[d],        1'b0);
        check({tag, "_done"},       done_s[d],        1'b0);
        check({tag, "_pass"},       pass_s[d],        1'b0);
        check({tag, "_fail_vec"},   fail_vec_s[d],    4'h0);
        check({tag, "_first_diff"}, first_diff_s[d],  8'h00);
        check({tag, "_ab"},         {a_s[d], b_s[d]}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (start_s[i]) start_s[i] = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < N_DUT; d++) check_idle(d, "reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: correct block, vector sequence 00,00,01,01,10,10,11,11 then done.
        fault_mode = 0;
        launch(0, 4'b0000, 8'h00, 1'b1, 1, 1'b1);
        for (int c = 0; c < 8; c++) begin
            check("t1_ab",   {a_s[0], b_s[0]}, c / 2);
            check("t1_busy", busy_s[0],        1'b1);
            @(negedge clk);
        end
        wait_done(0);

        // 2: xor stuck at 0 -> vectors 01 and 10 fail, diff 40.
        fault_mode = 1;
        launch(0, 4'b0110, 8'h40, 1'b0, 1, 1'b1);
        wait_done(0);

        // 3: and inverted on vector 11 only.
        fault_mode = 2;
        launch(0, 4'b1000, 8'h01, 1'b0, 1, 1'b1);
        wait_done(0);
        fault_mode = 0;

        // 4a: start held across the whole run -> one run, no restart after.
        launch(0, 4'b0000, 8'h00, 1'b1, 8, 1'b1);
        wait_done(0);
        repeat (3) @(negedge clk);
        check("t4_done_held", done_s[0], 1'b1);
        check("t4_pass_held", pass_s[0], 1'b1);
        check("t4_no_rerun",  busy_s[0], 1'b0);

        // 4b: rerun from DONE clears results; a mid-run pulse is ignored.
        launch(0, 4'b0000, 8'h00, 1'b1, 1, 1'b1);
        check("t4_clr_done", done_s[0], 1'b0);
        check("t4_clr_pass", pass_s[0], 1'b0);
        check("t4_busy",     busy_s[0], 1'b1);
        repeat (2) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_done(0);

        // 5: asynchronous reset during vector 2 with a failure already logged.
        fault_mode = 1;
        launch(0, 4'b0000, 8'h00, 1'b0, 1, 1'b0);
        repeat (4) @(negedge clk);
        check("t5_ab_vec2",   {a_s[0], b_s[0]}, 2'b10);
        check("t5_fail_pre",  fail_vec_s[0],    4'b0010);
        #2 rst_n = 1'b0;
        #1 check_idle(0, "t5_async");
        @(negedge clk);
        rst_n = 1'b1;
        fault_mode = 0;
        repeat (6) @(negedge clk);
        check_idle(0, "t5_after");

        // 6: SETTLE_CYC = 1 and 5 with a correct block.
        launch(1, 4'b0000, 8'h00, 1'b1, 1, 1'b1);
        wait_done(1);
        launch(2, 4'b0000, 8'h00, 1'b1, 1, 1'b1);
        wait_done(2);

        @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
